// File: rtl/xor_unit_pkg.sv
// rtl/xor_unit_pkg.sv - shared constants and result record for the XOR unit
package xor_unit_pkg;

  localparam int XOR_UNIT_DEFAULT_WIDTH = 1;
  localparam int XOR_UNIT_MAX_WIDTH     = 64;

  // Widest result record; per-instance stages carry only WIDTH+1 bits of it.
  typedef struct packed {
    logic [XOR_UNIT_MAX_WIDTH-1:0] data;
    logic                          parity;
  } xor_result_t;

endpackage

// File: rtl/xor_out_reg.sv
// rtl/xor_out_reg.sv - single-entry valid/ready register stage, refills while draining
module xor_out_reg #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q,  data_d;
  logic          accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Payload only moves on accept, so undefined operands are harmless while idle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/xor_unit.sv
// rtl/xor_unit.sv - bitwise XOR with a combinational port and a registered parity-tagged path
module xor_unit
  import xor_unit_pkg::*;
#(
  parameter int WIDTH = XOR_UNIT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] a_xor_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             parity;
  } result_t;

  result_t res_in;
  result_t res_out;

  assign a_xor_b = a ^ b;

  always_comb begin
    res_in.data   = a ^ b;
    res_in.parity = ^(a ^ b);
  end

  xor_out_reg #(
    .DW ($bits(result_t))
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (res_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (res_out)
  );

  assign out_data   = res_out.data;
  assign out_parity = res_out.parity;

endmodule

// File: tb/tb_xor_unit.sv
// tb/tb_xor_unit.sv - randomized self-checking bench for xor_unit against a queue model
module tb_xor_unit;
  import xor_unit_pkg::*;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n;

  logic [7:0] a, b, a_xor_b, out_data;
  logic       in_valid, in_ready, out_parity, out_valid, out_ready;

  logic [0:0] a1, b1, a_xor_b1, out_data1;
  logic       in_valid1, in_ready1, out_parity1, out_valid1, out_ready1;

  always #5 clk = clk_en ? ~clk : clk;

  xor_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .a_xor_b(a_xor_b), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_parity(out_parity), .out_valid(out_valid), .out_ready(out_ready)
  );

  xor_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a_xor_b(a_xor_b1), .a(a1), .b(b1),
    .in_valid(in_valid1), .in_ready(in_ready1), .out_data(out_data1),
    .out_parity(out_parity1), .out_valid(out_valid1), .out_ready(out_ready1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue holding the result waiting downstream, plus the last
  // result ever loaded (the output bus keeps it after delivery).
  xor_result_t pending[$];
  xor_result_t last_res;
  bit          model_known = 0;
  bit          chk_comb = 1;
  int          delivered = 0;

  function automatic xor_result_t make_res(input logic [7:0] x, input logic [7:0] y);
    xor_result_t r;
    r.data   = 64'(x ^ y);
    r.parity = ($countones(x ^ y) % 2) == 1;
    return r;
  endfunction

  task automatic cycle();
    bit acc;
    #1;
    if (chk_comb) expect_eq("comb8", 64'(a_xor_b), 64'(a ^ b));
    if (model_known) begin
      expect_eq("out_valid", 64'(out_valid), 64'(pending.size() > 0));
      expect_eq("out_data", 64'(out_data), last_res.data);
      expect_eq("out_parity", 64'(out_parity), 64'(last_res.parity));
      expect_eq("in_ready", 64'(in_ready), 64'(pending.size() == 0 || out_ready));
    end
    @(posedge clk);
    if (!rst_n) begin
      pending.delete();
      last_res = '0;
      model_known = 1;
    end else begin
      acc = in_valid && (pending.size() == 0 || out_ready);
      if (out_ready && pending.size() > 0) begin
        void'(pending.pop_front());
        delivered++;
      end
      if (acc) begin
        last_res = make_res(a, b);
        pending.push_back(last_res);
      end
    end
    @(negedge clk);
  endtask

  logic [0:0] sweep_a [4];
  logic [0:0] sweep_b [4];
  logic [0:0] sweep_y [4];
  int snap;

  initial begin
    sweep_a = '{1'b0, 1'b0, 1'b1, 1'b1};
    sweep_b = '{1'b0, 1'b1, 1'b1, 1'b0};
    sweep_y = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b1; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
    a1 = '0; b1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b0;

    // Combinational truth table, clock stopped, with and without reset.
    for (int r = 1; r >= 0; r--) begin
      rst_n = r[0];
      for (int i = 0; i < 4; i++) begin
        a1 = sweep_a[i]; b1 = sweep_b[i];
        #10;
        expect_eq(r ? "comb1" : "comb1_rst", 64'(a_xor_b1), 64'(sweep_y[i]));
      end
    end

    clk_en = 1'b1;
    @(negedge clk);

    // Reset with a pending offer: nothing may be captured.
    rst_n = 1'b0; in_valid = 1'b1; a = 8'h01; b = 8'h00;
    cycle(); cycle();
    expect_eq("rst_valid", 64'(out_valid), 64'd0);
    expect_eq("rst_data", 64'(out_data), 64'd0);
    expect_eq("rst_parity", 64'(out_parity), 64'd0);
    expect_eq("rst_valid_w1", 64'(out_valid1), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    expect_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Single transfer.
    a = 8'hA5; b = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    expect_eq("single_valid", 64'(out_valid), 64'd1);
    expect_eq("single_data", 64'(out_data), 64'hAA);
    expect_eq("single_parity", 64'(out_parity), 64'd0);
    cycle();
    expect_eq("single_drained", 64'(out_valid), 64'd0);
    expect_eq("single_data_kept", 64'(out_data), 64'hAA);

    // Back-pressure: result holds, new operands ignored.
    a = 8'hFF; b = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      cycle();
    end
    expect_eq("bp_data", 64'(out_data), 64'hFE);
    expect_eq("bp_parity", 64'(out_parity), 64'd1);
    expect_eq("bp_in_ready", 64'(in_ready), 64'd0);
    snap = delivered;
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle();
    expect_eq("bp_one_transfer", 64'(delivered - snap), 64'd1);
    expect_eq("bp_drained", 64'(out_valid), 64'd0);

    // Streaming at full throughput.
    snap = delivered;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      cycle();
      expect_eq("stream_no_bubble", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    cycle();
    expect_eq("stream_count", 64'(delivered - snap), 64'd16);

    // Reset while a result is held under back-pressure.
    a = 8'h3C; b = 8'h81; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    expect_eq("midrst_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    snap = delivered;
    cycle(); cycle();
    expect_eq("midrst_dropped", 64'(delivered - snap), 64'd0);
    expect_eq("midrst_idle", 64'(out_valid), 64'd0);

    // Random traffic, including undefined operands while idle.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid && $urandom_range(0, 3) == 0) begin
        a = 'x; b = 'x; chk_comb = 0;
      end else begin
        a = 8'($urandom); b = 8'($urandom); chk_comb = 1;
      end
      cycle();
    end
    chk_comb = 1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xor_unit.md
Name: xor_unit

Overview:
- Parameterised bitwise XOR block with a combinational result port and a registered, flow-controlled result path.
- The combinational port serves simple gate-level use: out = a ^ b, with no clock dependency.
- The registered path serves pipelined datapaths: a valid/ready stage with 1-cycle latency, plus a parity (reduction-XOR) flag.

Parameters:
- WIDTH, 1, bit width of a, b and all result buses (legal range 1..64).

Ports:
- clk  in  1  rising-edge clock for the registered path
- rst_n  in  1  synchronous reset, active-low; sampled on the rising edge of clk
- a_xor_b  out  WIDTH  combinational a ^ b
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- in_valid  in  1  a/b valid for the registered path
- in_ready  out  1  stage can accept a new operand pair
- out_data  out  WIDTH  registered a ^ b
- out_parity  out  1  registered ^(a ^ b), the reduction XOR of the result
- out_valid  out  1  out_data/out_parity valid
- out_ready  in  1  downstream accepts the output

Behaviour:
- Combinational path:
  - a_xor_b = a ^ b bitwise, zero latency.
  - Independent of clk, rst_n and the handshake.
  - Valid during reset.
  - Truth table per bit: 00->0, 01->1, 11->0, 10->1.
- Reset (rst_n==0 at a rising clk edge):
  - out_valid=0, out_data=0, out_parity=0.
  - Takes priority over any simultaneous transfer.
  - Reset mid-transfer drops the held result; nothing is replayed.
- in_ready = !out_valid || out_ready (combinational; a single register stage that refills in the same cycle it drains).
- Accept: when in_valid && in_ready at a rising edge, out_data <= a ^ b, out_parity <= ^(a ^ b), out_valid <= 1. Latency is exactly 1 cycle.
- Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid <= 0. out_data/out_parity keep their last value (not cleared).
- Simultaneous drain and accept: the new result replaces the old one and out_valid stays 1. No bubble, so full throughput is one result per cycle.
- Back-pressure: out_valid && !out_ready -> out_data/out_parity/out_valid hold. in_ready=0, so a and b are ignored.
- No combinational path from in_valid to out_valid.
- Width rules:
  - All buses are WIDTH bits; no sign semantics.
  - out_parity is 1 when the result has an odd number of 1 bits.
- X-safety: with in_valid==0, a and b may be X without disturbing registered state.

Decomposition:
- Shared package xor_unit_pkg:
  - constant XOR_UNIT_DEFAULT_WIDTH = 1;
  - typedef for the result record {data, parity} used by the output stage.
- One sub-module is natural: xor_out_reg, the generic valid/ready single-entry register stage, parameterised on payload width (WIDTH+1).
- The top level holds only the XOR/parity logic, the stage instance and the combinational port.

Test Plan:
- Combinational sweep (WIDTH=1), 10 ns per step, no clock activity:
  - a=0,b=0 -> a_xor_b=0
  - a=0,b=1 -> 1
  - a=1,b=1 -> 0
  - a=1,b=0 -> 1
  - Must also hold while rst_n=0.
- Reset: rst_n=0 for 2 edges with in_valid=1, a=1, b=0 -> out_valid=0, out_data=0, out_parity=0, and in_ready=1 after release.
- Single transfer (WIDTH=8): a=8'hA5, b=8'h0F, in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=8'hAA, out_parity=0; the following cycle out_valid=0.
- Back-pressure (WIDTH=8):
  - Accept a=8'hFF, b=8'h01 (out_data=8'hFE, parity=1), with out_ready=0 for 3 cycles.
  - Result holds and in_ready=0; new a/b are ignored.
  - Raise out_ready -> exactly one transfer of 8'hFE.
- Streaming: in_valid=1 and out_ready=1 for 16 consecutive cycles with random a/b -> 16 results in order, 1-cycle latency, no bubbles; each result checked against a^b and parity.
- Reset mid-operation: rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 next edge; the held result is never delivered.
